pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for a 5-stage MIPS-style core: ID decode, hazard detection
// (load-use, branch/jump flush, multi-cycle mult) and the ID/EX, EX/MEM, MEM/WB control registers.
module pipe_ctrl #(
    parameter int ALUOP_W     = 4,
    parameter int REG_W       = 5,
    parameter int MULT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        id_instr,
    input  logic               ex_zero,
    output logic               stall,
    output logic               flush,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [REG_W-1:0]   ex_wr_reg,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_reg_write,
    output logic [REG_W-1:0]   mem_wr_reg,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [REG_W-1:0]   wb_wr_reg
);

    localparam int CNT_W = ($clog2(MULT_CYCLES) > 3) ? $clog2(MULT_CYCLES) : 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam bit MULTI_CYCLE = (MULT_CYCLES > 1);
    localparam logic [ALUOP_W-1:0] OP_MULT = ALUOP_W'(5);

    // R-type funct codes; table position i decodes to ALU op i+1.
    localparam logic [47:0] FUNCT_TAB = {
        6'b101010, 6'b100111, 6'b100110, 6'b011000,
        6'b100101, 6'b100100, 6'b100010, 6'b100000
    };

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    typedef enum logic {
        IDLE,
        MBUSY
    } mstate_t;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             unused_bits;

    assign opcode      = id_instr[31:26];
    assign funct       = id_instr[5:0];
    assign rs          = id_instr[21 +: REG_W];
    assign rt          = id_instr[16 +: REG_W];
    assign rd          = id_instr[11 +: REG_W];
    assign unused_bits = ^id_instr[10:6];

    logic [7:0] funct_hit;
    logic [3:0] r_op;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_funct
            assign funct_hit[gi] = (funct == FUNCT_TAB[gi*6 +: 6]);
        end
    endgenerate

    always_comb begin
        r_op = '0;
        for (int i = 0; i < 8; i++) begin
            if (funct_hit[i]) begin
                r_op = 4'(i + 1);
            end
        end
    end

    // Decoded ID-stage controls
    logic               dec_alu_src;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic [REG_W-1:0]   dec_dst;
    logic               dec_we;
    logic               dec_mrd;
    logic               dec_mwr;
    logic               dec_m2r;
    logic               dec_br;
    logic               dec_jmp;
    logic               dec_uses_rs;
    logic               dec_uses_rt;

    always_comb begin
        dec_alu_src = 1'b0;
        dec_alu_op  = '0;
        dec_dst     = '0;
        dec_we      = 1'b0;
        dec_mrd     = 1'b0;
        dec_mwr     = 1'b0;
        dec_m2r     = 1'b0;
        dec_br      = 1'b0;
        dec_jmp     = 1'b0;
        dec_uses_rs = 1'b0;
        dec_uses_rt = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                if (r_op != 4'd0) begin
                    dec_alu_op  = ALUOP_W'(r_op);
                    dec_we      = 1'b1;
                    dec_dst     = rd;
                    dec_uses_rs = 1'b1;
                    dec_uses_rt = 1'b1;
                end
            end
            OPC_BEQ: begin
                dec_br      = 1'b1;
                dec_alu_src = 1'b1;
                dec_alu_op  = ALUOP_W'(9);
                dec_uses_rs = 1'b1;
                dec_uses_rt = 1'b1;
            end
            OPC_J: begin
                dec_jmp    = 1'b1;
                dec_alu_op = ALUOP_W'(10);
            end
            OPC_LW: begin
                dec_alu_src = 1'b1;
                dec_mrd     = 1'b1;
                dec_m2r     = 1'b1;
                dec_we      = 1'b1;
                dec_dst     = rt;
                dec_alu_op  = ALUOP_W'(11);
                dec_uses_rs = 1'b1;
            end
            OPC_SW: begin
                dec_alu_src = 1'b1;
                dec_mwr     = 1'b1;
                dec_alu_op  = ALUOP_W'(12);
                dec_uses_rs = 1'b1;
                dec_uses_rt = 1'b1;
            end
            default: begin
            end
        endcase
        // Writes to register 0 are discarded at decode.
        if (dec_dst == '0) begin
            dec_we = 1'b0;
        end
    end

    // Pipeline registers
    logic               idex_alu_src_reg, idex_alu_src_next;
    logic [ALUOP_W-1:0] idex_alu_op_reg,  idex_alu_op_next;
    logic [REG_W-1:0]   idex_dst_reg,     idex_dst_next;
    logic               idex_we_reg,      idex_we_next;
    logic               idex_mrd_reg,     idex_mrd_next;
    logic               idex_mwr_reg,     idex_mwr_next;
    logic               idex_m2r_reg,     idex_m2r_next;
    logic               idex_br_reg,      idex_br_next;
    logic               idex_jmp_reg,     idex_jmp_next;

    logic               exmem_mrd_reg,    exmem_mrd_next;
    logic               exmem_mwr_reg,    exmem_mwr_next;
    logic               exmem_we_reg,     exmem_we_next;
    logic               exmem_m2r_reg,    exmem_m2r_next;
    logic [REG_W-1:0]   exmem_dst_reg,    exmem_dst_next;

    logic               memwb_we_reg;
    logic               memwb_m2r_reg;
    logic [REG_W-1:0]   memwb_dst_reg;

    mstate_t            state_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic load_use;
    logic flush_int;
    logic mult_start;
    logic mult_busy;

    assign load_use = idex_mrd_reg &&
                      ((dec_uses_rs && (idex_dst_reg == rs)) ||
                       (dec_uses_rt && (idex_dst_reg == rt)));
    assign flush_int  = idex_jmp_reg || (idex_br_reg && ex_zero);
    assign mult_start = (state_reg == IDLE) && (idex_alu_op_reg == OP_MULT) && MULTI_CYCLE;
    assign mult_busy  = mult_start || ((state_reg == MBUSY) && (cnt_reg > CNT_W'(1)));

    assign flush = flush_int;
    assign stall = !flush_int && (load_use || mult_busy);

    always_comb begin
        idex_alu_src_next = idex_alu_src_reg;
        idex_alu_op_next  = idex_alu_op_reg;
        idex_dst_next     = idex_dst_reg;
        idex_we_next      = idex_we_reg;
        idex_mrd_next     = idex_mrd_reg;
        idex_mwr_next     = idex_mwr_reg;
        idex_m2r_next     = idex_m2r_reg;
        idex_br_next      = idex_br_reg;
        idex_jmp_next     = idex_jmp_reg;
        if (flush_int || (!mult_busy && load_use)) begin
            idex_alu_src_next = 1'b0;
            idex_alu_op_next  = '0;
            idex_dst_next     = '0;
            idex_we_next      = 1'b0;
            idex_mrd_next     = 1'b0;
            idex_mwr_next     = 1'b0;
            idex_m2r_next     = 1'b0;
            idex_br_next      = 1'b0;
            idex_jmp_next     = 1'b0;
        end else if (!mult_busy) begin
            idex_alu_src_next = dec_alu_src;
            idex_alu_op_next  = dec_alu_op;
            idex_dst_next     = dec_dst;
            idex_we_next      = dec_we;
            idex_mrd_next     = dec_mrd;
            idex_mwr_next     = dec_mwr;
            idex_m2r_next     = dec_m2r;
            idex_br_next      = dec_br;
            idex_jmp_next     = dec_jmp;
        end
    end

    // A mult still occupying EX sends bubbles downstream.
    always_comb begin
        exmem_mrd_next = idex_mrd_reg;
        exmem_mwr_next = idex_mwr_reg;
        exmem_we_next  = idex_we_reg;
        exmem_m2r_next = idex_m2r_reg;
        exmem_dst_next = idex_dst_reg;
        if (mult_busy && !flush_int) begin
            exmem_mrd_next = 1'b0;
            exmem_mwr_next = 1'b0;
            exmem_we_next  = 1'b0;
            exmem_m2r_next = 1'b0;
            exmem_dst_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_alu_src_reg <= 1'b0;
            idex_alu_op_reg  <= '0;
            idex_dst_reg     <= '0;
            idex_we_reg      <= 1'b0;
            idex_mrd_reg     <= 1'b0;
            idex_mwr_reg     <= 1'b0;
            idex_m2r_reg     <= 1'b0;
            idex_br_reg      <= 1'b0;
            idex_jmp_reg     <= 1'b0;
            exmem_mrd_reg    <= 1'b0;
            exmem_mwr_reg    <= 1'b0;
            exmem_we_reg     <= 1'b0;
            exmem_m2r_reg    <= 1'b0;
            exmem_dst_reg    <= '0;
            memwb_we_reg     <= 1'b0;
            memwb_m2r_reg    <= 1'b0;
            memwb_dst_reg    <= '0;
        end else begin
            idex_alu_src_reg <= idex_alu_src_next;
            idex_alu_op_reg  <= idex_alu_op_next;
            idex_dst_reg     <= idex_dst_next;
            idex_we_reg      <= idex_we_next;
            idex_mrd_reg     <= idex_mrd_next;
            idex_mwr_reg     <= idex_mwr_next;
            idex_m2r_reg     <= idex_m2r_next;
            idex_br_reg      <= idex_br_next;
            idex_jmp_reg     <= idex_jmp_next;
            exmem_mrd_reg    <= exmem_mrd_next;
            exmem_mwr_reg    <= exmem_mwr_next;
            exmem_we_reg     <= exmem_we_next;
            exmem_m2r_reg    <= exmem_m2r_next;
            exmem_dst_reg    <= exmem_dst_next;
            memwb_we_reg     <= exmem_we_reg;
            memwb_m2r_reg    <= exmem_m2r_reg;
            memwb_dst_reg    <= exmem_dst_reg;
        end
    end

    // Mult occupancy: MULT_CYCLES-1 stall cycles, released when cnt reaches 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mult_start) begin
                        state_reg <= MBUSY;
                        cnt_reg   <= CNT_LOAD;
                    end
                end
                MBUSY: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign ex_alu_src    = idex_alu_src_reg;
    assign ex_alu_op     = idex_alu_op_reg;
    assign ex_wr_reg     = idex_dst_reg;
    assign mem_read      = exmem_mrd_reg;
    assign mem_write     = exmem_mwr_reg;
    assign mem_reg_write = exmem_we_reg;
    assign mem_wr_reg    = exmem_dst_reg;
    assign wb_reg_write  = memwb_we_reg;
    assign wb_mem_to_reg = memwb_m2r_reg;
    assign wb_wr_reg     = memwb_dst_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: decode table, load-use stall, mult occupancy,
// branch/jump flush, rd=0 suppression and asynchronous reset in the middle of a mult.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        ex_zero;
    logic        stall;
    logic        flush;
    logic        ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_wr_reg;
    logic        mem_read;
    logic        mem_write;
    logic        mem_reg_write;
    logic [4:0]  mem_wr_reg;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_wr_reg;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] LW     = 32'h8C28_0000;  // lw  $8, 0($1)
    localparam logic [31:0] LW_RT8 = 32'h8C68_0000;  // lw  $8, 0($3)
    localparam logic [31:0] ADD    = 32'h0102_4820;  // add $9, $8, $2
    localparam logic [31:0] SUB_R8 = 32'h0068_2822;  // sub $5, $3, $8
    localparam logic [31:0] MULT   = 32'h0109_0018;  // mult, rd=0
    localparam logic [31:0] MULT10 = 32'h0109_5018;  // mult, rd=10
    localparam logic [31:0] BEQ    = 32'h1022_0004;
    localparam logic [31:0] JMP    = 32'h0800_0010;
    localparam logic [31:0] ADD0   = 32'h0022_0020;  // add $0, $1, $2

    pipe_ctrl #(.ALUOP_W(4), .REG_W(5), .MULT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_instr     (id_instr),
        .ex_zero      (ex_zero),
        .stall        (stall),
        .flush        (flush),
        .ex_alu_src   (ex_alu_src),
        .ex_alu_op    (ex_alu_op),
        .ex_wr_reg    (ex_wr_reg),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_reg_write(mem_reg_write),
        .mem_wr_reg   (mem_wr_reg),
        .wb_reg_write (wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_wr_reg    (wb_wr_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [31:0] instr, input logic z);
        id_instr = instr;
        ex_zero  = z;
        #1;
        $display("[%0t] %-10s id_instr=%08h ex_zero=%0b stall=%0b flush=%0b ex_op=%0d ex_wr=%0d",
                 $time, name, instr, z, stall, flush, ex_alu_op, ex_wr_reg);
    endtask

    task automatic drain();
        repeat (3) begin
            issue("nop", NOP, 1'b0);
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"},     stall,         0);
        chk({tag, "_flush"},     flush,         0);
        chk({tag, "_ex_src"},    ex_alu_src,    0);
        chk({tag, "_ex_op"},     ex_alu_op,     0);
        chk({tag, "_ex_wr"},     ex_wr_reg,     0);
        chk({tag, "_mem_rd"},    mem_read,      0);
        chk({tag, "_mem_wr"},    mem_write,     0);
        chk({tag, "_mem_rw"},    mem_reg_write, 0);
        chk({tag, "_mem_dst"},   mem_wr_reg,    0);
        chk({tag, "_wb_rw"},     wb_reg_write,  0);
        chk({tag, "_wb_m2r"},    wb_mem_to_reg, 0);
        chk({tag, "_wb_dst"},    wb_wr_reg,     0);
    endtask

    logic [31:0] tab_instr [11];
    logic [3:0]  tab_op    [11];
    logic [4:0]  tab_dst   [11];
    logic        tab_src   [11];

    initial begin
        tab_instr = '{32'h0102_4820, 32'h0102_4822, 32'h0102_4824, 32'h0102_4825,
                      32'h0102_4826, 32'h0102_4827, 32'h0102_482A, 32'h0102_483F,
                      32'h0102_4800, 32'hFC00_0000, 32'hAC28_0000};
        tab_op    = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd0, 4'd0, 4'd0, 4'd12};
        tab_dst   = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0};
        tab_src   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        id_instr = NOP;
        ex_zero  = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        id_instr = LW;
        tick();
        check_all_zero("rst_hold");
        rst_n = 1'b1;

        // Load-use on rs
        issue("lw", LW, 1'b0);
        chk("lu_pre_stall", stall, 0);
        tick();
        issue("add", ADD, 1'b0);
        chk("lu_ex_op_lw", ex_alu_op, 11);
        chk("lu_ex_wr_lw", ex_wr_reg, 8);
        chk("lu_ex_src_lw", ex_alu_src, 1);
        chk("lu_stall", stall, 1);
        chk("lu_flush", flush, 0);
        tick();
        issue("add_held", ADD, 1'b0);
        chk("lu_stall_once", stall, 0);
        chk("lu_bubble_op", ex_alu_op, 0);
        chk("lu_mem_read", mem_read, 1);
        chk("lu_mem_rw", mem_reg_write, 1);
        chk("lu_mem_dst", mem_wr_reg, 8);
        tick();
        issue("nop", NOP, 1'b0);
        chk("lu_add_op", ex_alu_op, 1);
        chk("lu_add_wr", ex_wr_reg, 9);
        chk("lu_wb_rw", wb_reg_write, 1);
        chk("lu_wb_m2r", wb_mem_to_reg, 1);
        chk("lu_wb_dst", wb_wr_reg, 8);
        chk("lu_mem_read_bub", mem_read, 0);
        tick();
        issue("nop", NOP, 1'b0);
        chk("add_mem_rw", mem_reg_write, 1);
        chk("add_mem_dst", mem_wr_reg, 9);
        chk("add_wb_bub", wb_reg_write, 0);
        tick();
        issue("nop", NOP, 1'b0);
        chk("add_wb_rw", wb_reg_write, 1);
        chk("add_wb_dst", wb_wr_reg, 9);
        chk("add_wb_m2r", wb_mem_to_reg, 0);
        tick();

        // lw ignores its rt for hazards; R-type rt does hazard
        issue("lw", LW, 1'b0);
        tick();
        issue("lw_rt8", LW_RT8, 1'b0);
        chk("lu_lw_rt_nohaz", stall, 0);
        tick();
        issue("sub_rt8", SUB_R8, 1'b0);
        chk("lu_rt_haz", stall, 1);
        tick();
        issue("sub_held", SUB_R8, 1'b0);
        chk("lu_rt_release", stall, 0);
        chk("lu_rt_bubble", ex_alu_op, 0);
        tick();
        issue("nop", NOP, 1'b0);
        chk("sub_op", ex_alu_op, 2);
        chk("sub_wr", ex_wr_reg, 5);
        tick();
        drain();

        // Decode table
        for (int i = 0; i < 11; i++) begin
            issue("dec", tab_instr[i], 1'b0);
            tick();
            chk($sformatf("dec%0d_op", i),  ex_alu_op,  tab_op[i]);
            chk($sformatf("dec%0d_wr", i),  ex_wr_reg,  tab_dst[i]);
            chk($sformatf("dec%0d_src", i), ex_alu_src, tab_src[i]);
        end
        issue("nop", NOP, 1'b0);
        tick();
        chk("sw_mem_write", mem_write, 1);
        chk("sw_mem_read", mem_read, 0);
        chk("sw_mem_rw", mem_reg_write, 0);
        drain();

        // Mult occupies EX for 4 cycles
        issue("mult", MULT, 1'b0);
        chk("mult_pre_stall", stall, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            issue("add_held", ADD, 1'b0);
            chk($sformatf("mult_stall%0d", k), stall, 1);
            chk($sformatf("mult_ex_op%0d", k), ex_alu_op, 5);
            chk($sformatf("mult_mem_rw%0d", k), mem_reg_write, 0);
            chk($sformatf("mult_mem_dst%0d", k), mem_wr_reg, 0);
            tick();
        end
        issue("add_held", ADD, 1'b0);
        chk("mult_release", stall, 0);
        chk("mult_last_op", ex_alu_op, 5);
        tick();
        issue("nop", NOP, 1'b0);
        chk("mult_next_op", ex_alu_op, 1);
        chk("mult_next_wr", ex_wr_reg, 9);
        chk("mult_next_stall", stall, 0);
        tick();
        drain();

        // Mult with rd=10: reaches EX/MEM only after the 4th cycle
        issue("mult10", MULT10, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            issue("nop_held", NOP, 1'b0);
            chk($sformatf("mult10_mem_bub%0d", k), mem_reg_write, 0);
            tick();
        end
        chk("mult10_mem_rw", mem_reg_write, 1);
        chk("mult10_mem_dst", mem_wr_reg, 10);
        drain();

        // beq taken / not taken
        issue("beq", BEQ, 1'b0);
        tick();
        issue("add_z1", ADD, 1'b1);
        chk("beq_flush", flush, 1);
        chk("beq_stall", stall, 0);
        chk("beq_ex_op", ex_alu_op, 9);
        chk("beq_ex_src", ex_alu_src, 1);
        tick();
        issue("nop", NOP, 1'b0);
        chk("beq_flush_once", flush, 0);
        chk("beq_killed_op", ex_alu_op, 0);
        tick();
        issue("beq", BEQ, 1'b0);
        tick();
        issue("add_z0", ADD, 1'b0);
        chk("beqnt_flush", flush, 0);
        chk("beqnt_ex_op", ex_alu_op, 9);
        tick();
        issue("nop", NOP, 1'b0);
        chk("beqnt_next_op", ex_alu_op, 1);
        tick();

        // jump
        issue("j", JMP, 1'b0);
        tick();
        issue("add", ADD, 1'b0);
        chk("j_flush", flush, 1);
        chk("j_ex_op", ex_alu_op, 10);
        tick();
        issue("nop", NOP, 1'b0);
        chk("j_killed_op", ex_alu_op, 0);
        chk("j_flush_once", flush, 0);
        tick();
        drain();

        // rd = 0
        issue("add_rd0", ADD0, 1'b0);
        tick();
        chk("rd0_ex_op", ex_alu_op, 1);
        chk("rd0_ex_wr", ex_wr_reg, 0);
        issue("nop", NOP, 1'b0);
        tick();
        chk("rd0_mem_rw", mem_reg_write, 0);
        chk("rd0_wb_rw_a", wb_reg_write, 0);
        tick();
        chk("rd0_wb_rw_b", wb_reg_write, 0);
        drain();

        // Reset during the second MBUSY cycle
        issue("mult", MULT, 1'b0);
        tick();
        issue("nop_held", NOP, 1'b0);
        chk("rm_stall_a", stall, 1);
        tick();
        issue("nop_held", NOP, 1'b0);
        chk("rm_stall_b", stall, 1);
        tick();
        chk("rm_before_op", ex_alu_op, 5);
        chk("rm_before_stall", stall, 1);
        rst_n = 1'b0;
        #1 check_all_zero("rm_async");
        tick();
        rst_n = 1'b1;
        issue("add", ADD, 1'b0);
        chk("rm_post_stall_a", stall, 0);
        tick();
        issue("nop", NOP, 1'b0);
        chk("rm_post_op", ex_alu_op, 1);
        chk("rm_post_wr", ex_wr_reg, 9);
        chk("rm_post_stall_b", stall, 0);
        tick();
        issue("nop", NOP, 1'b0);
        chk("rm_post_stall_c", stall, 0);
        chk("rm_post_mem_rw", mem_reg_write, 1);
        chk("rm_post_mem_dst", mem_wr_reg, 9);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
